// File: rtl/reload_down_counter.sv
// rtl/reload_down_counter.sv - loadable down counter with reload register, run/done FSM and terminal-count pulse
// Optional tick prescaler compiled in with DOWN_COUNTER_PRESCALE_EN.
module reload_down_counter #(
  parameter int WIDTH = 8
`ifdef DOWN_COUNTER_PRESCALE_EN
  ,
  parameter int PRE_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             auto_reload,
`ifdef DOWN_COUNTER_PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_pulse_q, tc_pulse_d;
  logic             pre_term;
  logic             tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  assign pre_term = (pre_q == prescale);

  // Prescaler only advances while enabled in RUN; any other state parks it at zero.
  always_comb begin
    pre_d = pre_q;
    if (load || state_q != ST_RUN) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = pre_term ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign pre_term = 1'b1;
`endif

  assign tick = enable && (state_q == ST_RUN) && pre_term;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    tc_pulse_d = 1'b0;
    if (load) begin
      count_d  = data_in;
      reload_d = data_in;
      state_d  = (data_in != '0) ? ST_RUN : ST_DONE;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        count_d    = '0;
        tc_pulse_d = 1'b1;
        state_d    = auto_reload ? ST_RUN : ST_DONE;
      end else if (auto_reload) begin
        // Reload of zero keeps count at 0 and pulses on every tick.
        count_d    = reload_q;
        tc_pulse_d = (reload_q == '0);
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      tc_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      tc_pulse_q <= tc_pulse_d;
    end
  end

  assign count    = count_q;
  assign tc       = (count_q == '0);
  assign tc_pulse = tc_pulse_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_reload_down_counter.sv
// tb/tb_reload_down_counter.sv - directed self-checking bench for reload_down_counter
module tb_reload_down_counter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             tc_pulse;
  logic             busy;
  logic             done;
`ifdef DOWN_COUNTER_PRESCALE_EN
  logic [3:0]       prescale;
`endif

  int tests  = 0;
  int failed = 0;

  reload_down_counter #(
    .WIDTH(WIDTH)
`ifdef DOWN_COUNTER_PRESCALE_EN
    ,
    .PRE_W(4)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .enable     (enable),
    .auto_reload(auto_reload),
`ifdef DOWN_COUNTER_PRESCALE_EN
    .prescale   (prescale),
`endif
    .count      (count),
    .tc         (tc),
    .tc_pulse   (tc_pulse),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] c, input logic p,
                         input logic b, input logic d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tc"}, 32'(tc), 32'(c == '0));
    chk({tag, ".tc_pulse"}, 32'(tc_pulse), 32'(p));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [WIDTH-1:0] exp_seq[6];
    logic [WIDTH-1:0] ar_seq[6];
    rst_n = 1'b0; load = 1'b0; data_in = '0; enable = 1'b0; auto_reload = 1'b0;
`ifdef DOWN_COUNTER_PRESCALE_EN
    prescale = 4'd0;
`endif
    // Reset held for two cycles, then released with no load.
    @(negedge clk); @(negedge clk);
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 8'd0, 1'b0, 1'b0, 1'b0);

    // One-shot countdown from 5.
    load = 1'b1; data_in = 8'd5; enable = 1'b1; auto_reload = 1'b0;
    @(negedge clk);
    load = 1'b0;
    chk_all("os_load", 8'd5, 1'b0, 1'b1, 1'b0);
    exp_seq = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all($sformatf("os_step%0d", i), exp_seq[i], exp_seq[i] == 0, exp_seq[i] != 0,
              exp_seq[i] == 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("os_hold%0d", i), 8'd0, 1'b0, 1'b0, 1'b1);
    end

    // Auto-reload with period 3.
    load = 1'b1; data_in = 8'd2; auto_reload = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk_all("ar_load", 8'd2, 1'b0, 1'b1, 1'b0);
    ar_seq = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_all($sformatf("ar_step%0d", i), ar_seq[i], ar_seq[i] == 0, 1'b1, 1'b0);
    end

    // Load wins over a pending decrement.
    load = 1'b1; data_in = 8'd6; auto_reload = 1'b0;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all("pri_at4", 8'd4, 1'b0, 1'b1, 1'b0);
    load = 1'b1; data_in = 8'd9;
    @(negedge clk);
    load = 1'b0;
    chk_all("pri_reload", 8'd9, 1'b0, 1'b1, 1'b0);

    // Pause.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("pause%0d", i), 8'd9, 1'b0, 1'b1, 1'b0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk_all("resume", 8'd8, 1'b0, 1'b1, 1'b0);

    // Loading zero goes straight to DONE without a pulse.
    load = 1'b1; data_in = 8'd0;
    @(negedge clk);
    load = 1'b0;
    chk_all("load_zero", 8'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_all("load_zero_hold", 8'd0, 1'b0, 1'b0, 1'b1);

    // One-shot from 1 fires at once.
    load = 1'b1; data_in = 8'd1;
    @(negedge clk);
    load = 1'b0;
    chk_all("one_load", 8'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("one_tc", 8'd0, 1'b1, 1'b0, 1'b1);

`ifdef DOWN_COUNTER_PRESCALE_EN
    // Divide-by-3 prescaler.
    prescale = 4'd2;
    load = 1'b1; data_in = 8'd3;
    @(negedge clk);
    load = 1'b0;
    chk_all("pre_load", 8'd3, 1'b0, 1'b1, 1'b0);
    begin
      logic [WIDTH-1:0] ps[9];
      ps = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        chk_all($sformatf("pre_step%0d", i), ps[i], ps[i] == 0, ps[i] != 0, ps[i] == 0);
      end
    end
    prescale = 4'd0;
`endif

    // Asynchronous reset in the middle of a run.
    load = 1'b1; data_in = 8'd5;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all("mid_at3", 8'd3, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_async", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("mid_held", 8'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("mid_release", 8'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reload_down_counter.md
# reload_down_counter

Parametrised loadable down counter and the next generation of the team's 8-bit loadable down counter. It adds configurable width, a reload register with one-shot and auto-reload modes, a run/done state machine, a registered terminal-count pulse and an optional tick prescaler. Intended as the general-purpose timeout/period generator for level-0/1 blocks.

## Interface
- WIDTH, default 8: counter, `data_in` and reload register width (≥2).
- PRE_W, default 4: prescaler width (used only when the prescaler is compiled in).

Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  writes `data_in` into `count` and the reload register.
- data_in  in  WIDTH  load value.
- enable  in  1  tick gate; low pauses counting and holds all state.
- auto_reload  in  1  1 = periodic mode, 0 = one-shot mode; sampled on every tick.
- prescale  in  PRE_W  tick divider, divide by prescale+1 (present only with DOWN_COUNTER_PRESCALE_EN).
- count  out  WIDTH  current count (registered).
- tc  out  1  combinational, `count == 0`.
- tc_pulse  out  1  registered, one cycle per tick that leaves `count` at 0.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

## Operation
- States: IDLE (after reset), RUN, DONE.
- tick = `enable` && state==RUN && prescaler terminal. Without the prescaler, tick = `enable` && state==RUN.
- load (any state, highest priority):
  - `count` <= `data_in`; reload <= `data_in`; prescaler cleared; `tc_pulse` <= 0.
  - Next state RUN if `data_in` != 0, else DONE.
- RUN, tick, `count` > 1: `count` <= `count` - 1.
- RUN, tick, `count` == 1: `count` <= 0; `tc_pulse` <= 1.
  - `auto_reload` = 0 → DONE.
  - `auto_reload` = 1 → stay in RUN.
- RUN, tick, `count` == 0 (auto-reload only):
  - `auto_reload` = 1: `count` <= reload; `tc_pulse` <= 1 if reload == 0, else 0.
  - `auto_reload` = 0: go to DONE, `count` holds 0, no pulse.
- Period in auto-reload mode = reload+1 ticks; one `tc_pulse` per period.
- Reload of 0 in auto-reload mode: `count` stays 0 and `tc_pulse` fires on every tick.
- DONE and IDLE: `count` holds; exit only via load.
- The counter never wraps below 0. Decrement is modulo-free and never underflows.
- Load during an active tick: load wins and the decrement is discarded.
- Enable low: `count`, state and prescaler hold; `tc_pulse` <= 0.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `count` = 0, reload = 0, prescaler = 0, state = IDLE.
  - `tc` = 1, `tc_pulse` = 0, `busy` = 0, `done` = 0.
- Release of `rst_n` takes effect from the next rising edge.
- Load latency: 1 cycle. `count` = `data_in` and `busy` = 1 at the edge that samples load.
- `tc_pulse` is high for exactly the one cycle in which `count` first shows 0 (or shows the reloaded 0); otherwise it is 0.
- `tc` follows `count` combinationally, with no extra latency.
- Reset mid-RUN aborts immediately. No pulse is generated and no state is retained.

## Configuration
- DOWN_COUNTER_PRESCALE_EN defined:
  - The `prescale` port and a PRE_W-bit prescaler exist.
  - The prescaler counts up on `enable` in RUN; at value == `prescale` it asserts tick and clears.
  - It clears on load and whenever state != RUN.
  - `prescale` = 0 gives one tick per enabled cycle.
- DOWN_COUNTER_PRESCALE_EN undefined:
  - No `prescale` port and no prescaler logic.
  - Every enabled RUN cycle is a tick.

## Test plan
- Reset: `rst_n`=0 for 2 cycles → `count`=0, `tc`=1, `tc_pulse`=0, `busy`=0, `done`=0; same values after release with no load.
- One-shot: load 5, `enable`=1, `auto_reload`=0 → `count` 5,4,3,2,1,0 on consecutive negedges. `tc_pulse`=1 only at 0. Then `done`=1, `busy`=0, and `count` holds 0 for 3 more cycles.
- Auto-reload: load 2, `auto_reload`=1 → `count` 2,1,0,2,1,0,2. `tc_pulse` high every 3rd cycle; `busy` stays 1.
- Priority and pause:
  - Load 9 while in RUN at `count`=4 with `enable`=1 → next `count`=9, not 3.
  - `enable`=0 for 3 cycles → `count` held, `tc_pulse`=0.
- Prescaler (macro defined): `prescale`=2, load 3 → `count` 3,3,3,2,2,2,1,1,1,0. One `tc_pulse`.
- Mid-run reset: `rst_n` low asynchronously at `count`=3 → `count`=0, state IDLE before the next edge; no `tc_pulse`.
